booth_aq_shift_reg: RTL and testbench

Parametrised accumulator/multiplier register pair (A:Q:q-1) for the Booth multiplier datapath. It replaces the single accumulator register with a fully synchronous, enable-driven block. It holds the partial product A and the multiplier Q, and performs arithmetic right shifts of 1 (radix-2) or 2 (radix-4) bits per step. It exposes the Booth recoding bits, counts iterations and flags completion for the control unit.

---
 rtl/booth_aq_shift_reg_pkg.sv | 36 +++
 rtl/booth_aq_shift_reg_iter_counter.sv | 32 +++
 rtl/booth_aq_shift_reg.sv | 113 +++++++++++
 tb/tb_booth_aq_shift_reg.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/booth_aq_shift_reg_pkg.sv
// Shared Booth multiplier definitions: default sizes, iteration count helper, recoding ops.
// Latency: n/a (package only).
// Backpressure: n/a.
package booth_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_RADIX_LOG2 = 2;

    // Number of shift steps needed to consume every multiplier bit
    function automatic int iter_count(input int width, input int radix_log2);
        return width / radix_log2;
    endfunction

    // Operation selected by the controller from booth_bits
    typedef enum logic [2:0] {
        ZERO,
        PLUS_M,
        PLUS_2M,
        MINUS_2M,
        MINUS_M
    } booth_op_t;

    // Radix-4 recoding of {q[1:0], q_m1}
    function automatic booth_op_t booth_decode_r4(input logic [2:0] bits);
        booth_op_t op;
        case (bits)
            3'b001, 3'b010: op = PLUS_M;
            3'b011:         op = PLUS_2M;
            3'b100:         op = MINUS_2M;
            3'b101, 3'b110: op = MINUS_M;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_aq_shift_reg_iter_counter.sv
// Shift-step counter with sticky done flag; saturates at ITER.
// Latency: 1 cycle from inc to cnt/done update.
// Backpressure: inc is ignored once done is set; clear restarts.
module booth_iter_counter #(
    parameter int ITER  = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    // Count accepted steps; done rises in the same update that cnt reaches ITER
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (inc && !done) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(ITER - 1)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_aq_shift_reg.sv
// A:Q:q_m1 register pair for the Booth multiplier, arithmetic right shift by RADIX_LOG2 per step.
// Latency: 1 cycle for load/shift; booth_bits combinational from registers.
// Backpressure: shifts ignored once done; FUSED_ADD_SHIFT_EN selects add-then-shift vs. load_a-wins.
module booth_aq_shift_reg
    import booth_pkg::*;
#(
    parameter  int WIDTH      = DEF_WIDTH,
    parameter  int RADIX_LOG2 = DEF_RADIX_LOG2,
    localparam int ITER       = iter_count(WIDTH, RADIX_LOG2),
    localparam int CNT_W      = $clog2(ITER + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load_q,
    input  logic [WIDTH-1:0]      q_in,
    input  logic                  load_a,
    input  logic [WIDTH:0]        sum,
    input  logic                  shift,
    output logic [WIDTH:0]        rez_a,
    output logic [WIDTH-1:0]      rez_q,
    output logic                  q_m1,
    output logic [RADIX_LOG2:0]   booth_bits,
    output logic [CNT_W-1:0]      iter_cnt,
    output logic                  done,
    output logic                  collision
);

    localparam int TOT = 2 * WIDTH + 2;

    logic [WIDTH:0]          shift_src_a;
    logic                    shift_go;
    logic                    coll_set;
    logic signed [TOT-1:0]   shifted;

    // Decide whether a shift step is taken this cycle and which A value feeds it
    always_comb begin
        shift_src_a = rez_a;
        shift_go    = shift && !done && !load_q && !clear;
        coll_set    = 1'b0;
`ifdef FUSED_ADD_SHIFT_EN
        // Adder result goes straight into the shifter, saving a cycle per step
        if (load_a) begin
            shift_src_a = sum;
        end
`else
        // Load wins; the dropped shift is flagged so the controller bug is visible
        if (load_a) begin
            shift_go = 1'b0;
        end
        coll_set = load_a && shift;
`endif
        shifted = $signed({shift_src_a, rez_q, q_m1}) >>> RADIX_LOG2;
    end

    // Accumulator: clear > shift step (possibly fused) > plain load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rez_a <= '0;
        end else if (clear) begin
            rez_a <= '0;
        end else if (shift_go) begin
            rez_a <= shifted[TOT-1 -: WIDTH+1];
        end else if (load_a) begin
            rez_a <= sum;
        end
    end

    // Multiplier and extra Booth bit: load_q overrides any shift
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rez_q <= '0;
            q_m1  <= 1'b0;
        end else begin
            if (load_q) begin
                rez_q <= q_in;
            end else if (shift_go) begin
                rez_q <= shifted[WIDTH:1];
            end
            if (clear || load_q) begin
                q_m1 <= 1'b0;
            end else if (shift_go) begin
                q_m1 <= shifted[0];
            end
        end
    end

    // Sticky collision flag, only cleared by clear or reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            collision <= 1'b0;
        end else if (clear) begin
            collision <= 1'b0;
        end else if (coll_set) begin
            collision <= 1'b1;
        end
    end

    booth_iter_counter #(
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (shift_go),
        .cnt   (iter_cnt),
        .done  (done)
    );

    assign booth_bits = {rez_q[RADIX_LOG2-1:0], q_m1};

endmodule

// File: tb/tb_booth_aq_shift_reg.sv
// Directed test of booth_aq_shift_reg (WIDTH=8, RADIX_LOG2=2) with an expected-value queue.
// Latency: expectations pushed 1 ns after the edge, compared at the following falling edge.
// Backpressure: n/a.
module tb_booth_aq_shift_reg;

    typedef struct packed {
        logic [8:0] a;
        logic [7:0] q;
        logic       qm1;
        logic [2:0] bb;
        logic [2:0] cnt;
        logic       done;
        logic       coll;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       load_q;
    logic [7:0] q_in;
    logic       load_a;
    logic [8:0] sum;
    logic       shift;
    logic [8:0] rez_a;
    logic [7:0] rez_q;
    logic       q_m1;
    logic [2:0] booth_bits;
    logic [2:0] iter_cnt;
    logic       done;
    logic       collision;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    errors;

    booth_aq_shift_reg #(
        .WIDTH      (8),
        .RADIX_LOG2 (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .load_q     (load_q),
        .q_in       (q_in),
        .load_a     (load_a),
        .sum        (sum),
        .shift      (shift),
        .rez_a      (rez_a),
        .rez_q      (rez_q),
        .q_m1       (q_m1),
        .booth_bits (booth_bits),
        .iter_cnt   (iter_cnt),
        .done       (done),
        .collision  (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [8:0] a, input logic [7:0] q, input logic qm1,
                                input logic [2:0] bb, input logic [2:0] cnt,
                                input logic dn, input logic coll);
        exp_t e;
        e.a = a; e.q = q; e.qm1 = qm1; e.bb = bb; e.cnt = cnt; e.done = dn; e.coll = coll;
        return e;
    endfunction

    // Monitor: compare the DUT state against the oldest pending expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            exp_t  act;
            string nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = mk(rez_a, rez_q, q_m1, booth_bits, iter_cnt, done, collision);
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got a=%h q=%h qm1=%b bb=%b cnt=%0d done=%b coll=%b, want a=%h q=%h qm1=%b bb=%b cnt=%0d done=%b coll=%b",
                         nm, act.a, act.q, act.qm1, act.bb, act.cnt, act.done, act.coll,
                         e.a, e.q, e.qm1, e.bb, e.cnt, e.done, e.coll);
            end
        end
    end

    // Drive one cycle of controls, then queue the state expected after that edge
    task automatic step(input logic c, input logic lq, input logic [7:0] qi,
                        input logic la, input logic [8:0] sm, input logic sh,
                        input exp_t e, input string nm);
        clear = c; load_q = lq; q_in = qi; load_a = la; sum = sm; shift = sh;
        @(posedge clk);
        #1;
        clear = 1'b0; load_q = 1'b0; q_in = '0; load_a = 1'b0; sum = '0; shift = 1'b0;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    initial begin
        exp_t e_coll;
        exp_t e_clr;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clear = 1'b0; load_q = 1'b0; q_in = '0; load_a = 1'b0; sum = '0; shift = 1'b0;

        @(negedge clk);
        exp_q.push_back(mk(9'h000, 8'h00, 1'b0, 3'b000, 3'd0, 1'b0, 1'b0));
        name_q.push_back("reset_state");
        @(negedge clk);
        reset = 1'b1;

        step(1, 1, 8'hB5, 0, 9'h000, 0, mk(9'h000, 8'hB5, 0, 3'b010, 3'd0, 0, 0), "clear_load_q");
        step(0, 0, 8'h00, 1, 9'h1F0, 0, mk(9'h1F0, 8'hB5, 0, 3'b010, 3'd0, 0, 0), "load_a");
        step(0, 0, 8'h00, 0, 9'h000, 1, mk(9'h1FC, 8'h2D, 0, 3'b010, 3'd1, 0, 0), "shift1");
        step(0, 0, 8'h00, 0, 9'h000, 1, mk(9'h1FF, 8'h0B, 0, 3'b110, 3'd2, 0, 0), "shift2");
        step(0, 0, 8'h00, 0, 9'h000, 1, mk(9'h1FF, 8'hC2, 1, 3'b101, 3'd3, 0, 0), "shift3");
        step(0, 0, 8'h00, 0, 9'h000, 1, mk(9'h1FF, 8'hF0, 1, 3'b001, 3'd4, 1, 0), "shift4_done");
        step(0, 0, 8'h00, 0, 9'h000, 1, mk(9'h1FF, 8'hF0, 1, 3'b001, 3'd4, 1, 0), "shift5_ignored");
        step(0, 0, 8'h00, 1, 9'h0AA, 0, mk(9'h0AA, 8'hF0, 1, 3'b001, 3'd4, 1, 0), "load_a_when_done");

        step(1, 1, 8'hB5, 0, 9'h000, 0, mk(9'h000, 8'hB5, 0, 3'b010, 3'd0, 0, 0), "restart");
        step(0, 0, 8'h00, 1, 9'h1F0, 0, mk(9'h1F0, 8'hB5, 0, 3'b010, 3'd0, 0, 0), "reload_a");
`ifdef FUSED_ADD_SHIFT_EN
        e_coll = mk(9'h001, 8'h2D, 0, 3'b010, 3'd1, 0, 0);
        e_clr  = mk(9'h000, 8'h2D, 0, 3'b010, 3'd0, 0, 0);
`else
        e_coll = mk(9'h004, 8'hB5, 0, 3'b010, 3'd0, 0, 1);
        e_clr  = mk(9'h000, 8'hB5, 0, 3'b010, 3'd0, 0, 0);
`endif
        step(0, 0, 8'h00, 1, 9'h004, 1, e_coll, "load_a_with_shift");
        step(1, 0, 8'h00, 1, 9'h123, 1, e_clr, "clear_beats_all");
        step(0, 1, 8'h3C, 0, 9'h000, 1, mk(9'h000, 8'h3C, 0, 3'b000, 3'd0, 0, 0), "load_q_beats_shift");
        step(0, 0, 8'h00, 1, 9'h055, 0, mk(9'h055, 8'h3C, 0, 3'b000, 3'd0, 0, 0), "preload");

        // Asynchronous reset mid-cycle: state must be zero before the next rising edge
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_q.push_back(mk(9'h000, 8'h00, 1'b0, 3'b000, 3'd0, 1'b0, 1'b0));
        name_q.push_back("async_reset");
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        step(0, 0, 8'h00, 0, 9'h000, 1, mk(9'h000, 8'h00, 0, 3'b000, 3'd1, 0, 0), "after_reset_shift");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
